dbg_bus_ctrl: RTL and testbench

//  Single-master debug bus controller between the host bridge and the MCS-4 core.

---
 rtl/dbg_bus_ctrl.sv | 112 +++++++++++
 tb/tb_dbg_bus_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_bus_ctrl.sv
// dbg_bus_ctrl: single-outstanding debug bus bridge decoding host accesses to local control regs, ROM or RAM
module dbg_bus_ctrl #(
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYC = 255,
  parameter bit SYS_RST_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic [13:0]       dbg_req_addr,
  input  logic              dbg_req_we,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [DATA_W-1:0] dbg_rsp_rdata,
  output logic              dbg_rsp_err,
  output logic              sys_rst_o,
  input  logic [11:0]       cpu_pc_i,
  input  logic [7:0]        cpu_instr_i,
  input  logic [63:0]       cpu_idxreg_i,
  output logic [11:0]       mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              rom_req_o,
  input  logic              rom_ack_i,
  input  logic [DATA_W-1:0] rom_rdata_i,
  output logic              ram_req_o,
  input  logic              ram_ack_i,
  input  logic [DATA_W-1:0] ram_rdata_i
);
  typedef enum logic [2:0] {IDLE, CTL, MEM_WAIT, ERR, RESP} state_t;
  state_t state;
  logic [13:0] addr_q;
  logic we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0] cnt;
  logic [7:0] ctl_rd;
  logic mem_req;
  assign mem_req = rom_req_o | ram_req_o;
  assign dbg_req_ready = state == IDLE;
  assign dbg_rsp_valid = state == RESP;
  assign mem_addr_o = mem_req ? addr_q[11:0] : '0;
  assign mem_we_o = mem_req & we_q;
  assign mem_wdata_o = mem_req ? wdata_q : '0;
  always_comb begin
    ctl_rd = addr_q[11:0] == 12'h000 ? {7'b0, sys_rst_o} :
             addr_q[11:0] == 12'h004 ? cpu_pc_i[7:0] :
             addr_q[11:0] == 12'h005 ? {4'b0, cpu_pc_i[11:8]} :
             addr_q[11:0] == 12'h006 ? cpu_instr_i :
             addr_q[11:3] == 9'h001  ? cpu_idxreg_i[{addr_q[2:0], 3'b000} +: 8] : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      cnt <= '0;
      dbg_rsp_rdata <= '0;
      dbg_rsp_err <= 1'b0;
      rom_req_o <= 1'b0;
      ram_req_o <= 1'b0;
      sys_rst_o <= SYS_RST_INIT;
    end else begin
      case (state)
        IDLE: if (dbg_req_valid) begin
          addr_q <= dbg_req_addr;
          we_q <= dbg_req_we;
          wdata_q <= dbg_req_wdata;
          cnt <= '0;
          dbg_rsp_rdata <= '0;
          dbg_rsp_err <= 1'b0;
          rom_req_o <= dbg_req_addr[13:12] == 2'd1;
          ram_req_o <= dbg_req_addr[13:12] == 2'd2;
          state <= dbg_req_addr[13:12] == 2'd0 ? CTL : dbg_req_addr[13:12] == 2'd3 ? ERR : MEM_WAIT;
        end
        CTL: begin
          dbg_rsp_rdata <= we_q ? '0 : DATA_W'(ctl_rd);
          if (we_q && addr_q[11:0] == 12'h000) sys_rst_o <= wdata_q[0];
          state <= RESP;
        end
        MEM_WAIT: begin
          // an ack arriving on the timeout cycle still completes the access cleanly
          if ((rom_req_o && rom_ack_i) || (ram_req_o && ram_ack_i)) begin
            dbg_rsp_rdata <= we_q ? '0 : rom_req_o ? rom_rdata_i : ram_rdata_i;
            rom_req_o <= 1'b0;
            ram_req_o <= 1'b0;
            state <= RESP;
          end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
            rom_req_o <= 1'b0;
            ram_req_o <= 1'b0;
            dbg_rsp_err <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ERR: begin
          dbg_rsp_err <= 1'b1;
          state <= RESP;
        end
        RESP: if (dbg_rsp_ready) begin
          dbg_rsp_rdata <= '0;
          dbg_rsp_err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbg_bus_ctrl.sv
// tb_dbg_bus_ctrl: randomized scoreboard bench with a behavioural model and a ROM/RAM responder
module tb_dbg_bus_ctrl;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0;
  logic dbg_req_valid = 0, dbg_req_ready, dbg_req_we = 0;
  logic [13:0] dbg_req_addr = 0;
  logic [7:0] dbg_req_wdata = 0, dbg_rsp_rdata;
  logic dbg_rsp_valid, dbg_rsp_ready = 0, dbg_rsp_err, sys_rst_o;
  logic [11:0] cpu_pc_i = 0, mem_addr_o;
  logic [7:0] cpu_instr_i = 0, mem_wdata_o, rom_rdata_i = 0, ram_rdata_i = 0;
  logic [63:0] cpu_idxreg_i = 0;
  logic mem_we_o, rom_req_o, ram_req_o, rom_ack_i = 0, ram_ack_i = 0;

  dbg_bus_ctrl #(.DATA_W(8), .TIMEOUT_CYC(TO), .SYS_RST_INIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_addr(dbg_req_addr),
    .dbg_req_we(dbg_req_we), .dbg_req_wdata(dbg_req_wdata),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_rdata(dbg_rsp_rdata),
    .dbg_rsp_err(dbg_rsp_err), .sys_rst_o(sys_rst_o),
    .cpu_pc_i(cpu_pc_i), .cpu_instr_i(cpu_instr_i), .cpu_idxreg_i(cpu_idxreg_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .rom_req_o(rom_req_o), .rom_ack_i(rom_ack_i), .rom_rdata_i(rom_rdata_i),
    .ram_req_o(ram_req_o), .ram_ack_i(ram_ack_i), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [7:0] rdata; logic err; int acc; int lat;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  logic [7:0] mem [2][4096];
  logic [7:0] ref_mem [2][4096];
  logic model_rst = 1;
  int cur_seg = 0, ack_delay = 0, exp_req = 0, hold_req = 0;
  logic [11:0] cur_addr = 0;
  logic cur_we = 0, stale_ack = 0;
  logic [7:0] cur_wd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ctl_model(int a);
    if (a == 0) return {7'b0, model_rst};
    if (a == 4) return cpu_pc_i[7:0];
    if (a == 5) return {4'b0, cpu_pc_i[11:8]};
    if (a == 6) return cpu_instr_i;
    if (a >= 8 && a <= 15) return 8'((cpu_idxreg_i >> (8 * (a - 8))) & 64'hFF);
    return 8'h00;
  endfunction

  task automatic do_txn(input logic [13:0] a, input logic we, input logic [7:0] wd, input int d, input bit wait_done);
    exp_t e;
    int t = 0;
    int seg = int'(a[13:12]);
    int a12 = int'(a[11:0]);
    int eff = d > TO ? TO : d;
    @(negedge clk);
    while (!dbg_req_ready && t < 500) begin @(negedge clk); t++; end
    chk("req_ready_before_issue", dbg_req_ready, 1);
    if (!dbg_req_ready) return;
    cur_seg = seg; cur_addr = a[11:0]; cur_we = we; cur_wd = wd; ack_delay = d; exp_req = eff;
    e.acc = cyc; e.rdata = 0; e.err = 0; e.lat = 2;
    if (seg == 0) begin
      if (!we) e.rdata = ctl_model(a12);
      else if (a12 == 0) model_rst = wd[0];
    end else if (seg == 3) begin
      e.err = 1;
    end else begin
      e.lat = eff + 1;
      if (d > TO) e.err = 1;
      else if (we) ref_mem[seg-1][a12] = wd;
      else e.rdata = ref_mem[seg-1][a12];
    end
    q.push_back(e);
    dbg_req_valid = 1; dbg_req_addr = a; dbg_req_we = we; dbg_req_wdata = wd;
    @(negedge clk);
    dbg_req_valid = 0; dbg_req_addr = $urandom; dbg_req_we = $urandom; dbg_req_wdata = $urandom;
    if (wait_done) begin
      t = 0;
      while (!dbg_req_ready && t < 500) begin @(negedge clk); t++; end
      chk("txn_complete", dbg_req_ready, 1);
      chk("sys_rst_o", sys_rst_o, model_rst);
    end
  endtask

  // memory responder: acks on the ack_delay-th request cycle and checks the memory-side bus
  initial begin
    int n = 0;
    bit prev = 0;
    forever begin
      @(negedge clk);
      rom_ack_i = 0; ram_ack_i = 0; rom_rdata_i = $urandom; ram_rdata_i = $urandom;
      if (!rst_n) begin
        n = 0; prev = 0;
      end else if (rom_req_o || ram_req_o) begin
        n++; prev = 1;
        chk("req_seg", {rom_req_o, ram_req_o}, cur_seg == 1 ? 2'b10 : cur_seg == 2 ? 2'b01 : 2'b00);
        chk("mem_addr", mem_addr_o, cur_addr);
        chk("mem_we", mem_we_o, cur_we);
        chk("mem_wdata", mem_wdata_o, cur_wd);
        if (n == ack_delay && cur_seg inside {1, 2}) begin
          if (cur_we) mem[cur_seg-1][cur_addr] = cur_wd;
          if (cur_seg == 1) begin rom_ack_i = 1; rom_rdata_i = mem[0][cur_addr]; end
          else begin ram_ack_i = 1; ram_rdata_i = mem[1][cur_addr]; end
        end
      end else begin
        if (prev) chk("req_cycles", n, exp_req);
        n = 0; prev = 0;
        chk("mem_idle", {mem_addr_o, mem_we_o, mem_wdata_o}, 0);
        if (stale_ack || $urandom_range(3) == 0) begin rom_ack_i = 1; ram_ack_i = 1; end
      end
    end
  end

  // response monitor: pops the scoreboard on each new response and checks hold stability
  initial begin
    bit in_rsp = 0;
    int hold = 0;
    logic [7:0] sr = 0;
    logic se = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_rsp = 0; dbg_rsp_ready = 0;
      end else if (dbg_rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1; hold = hold_req; hold_req = 0;
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b with no request pending", dbg_rsp_rdata, dbg_rsp_err);
          end else begin
            e = q.pop_front();
            chk("rsp_latency", cyc - e.acc, e.lat);
            chk("rsp_rdata", dbg_rsp_rdata, e.rdata);
            chk("rsp_err", dbg_rsp_err, e.err);
          end
          sr = dbg_rsp_rdata; se = dbg_rsp_err;
        end else begin
          chk("rsp_stable_rdata", dbg_rsp_rdata, sr);
          chk("rsp_stable_err", dbg_rsp_err, se);
        end
        chk("ready_low_in_resp", dbg_req_ready, 0);
        if (hold > 0) begin hold--; dbg_rsp_ready = 0; end
        else dbg_rsp_ready = 1'($urandom_range(1));
      end else begin
        in_rsp = 0; dbg_rsp_ready = 1'($urandom_range(1));
      end
    end
  end

  initial begin
    int t;
    int seg;
    int a12;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4096; i++) begin
        mem[s][i] = 8'($urandom);
        ref_mem[s][i] = mem[s][i];
      end
    // T1: reset state and releasing the core
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_sys_rst", sys_rst_o, 1);
    chk("rst_rsp_valid", dbg_rsp_valid, 0);
    chk("rst_reqs", {rom_req_o, ram_req_o}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", dbg_req_ready, 1);
    chk("post_rst_sys_rst", sys_rst_o, 1);
    do_txn(14'h0000, 1, 8'h00, 0, 1);
    // T2: CPU state readback
    cpu_pc_i = 12'hABC; cpu_instr_i = 8'h5F; cpu_idxreg_i = 64'h0123_4567_89AB_CDEF;
    for (int a = 0; a < 18; a++) do_txn(14'(a), 0, 8'h00, 0, 1);
    // T3: RAM read acked on the third request cycle
    mem[1][12'h123] = 8'hA5; ref_mem[1][12'h123] = 8'hA5;
    do_txn(14'h2123, 0, 8'h00, 3, 1);
    do_txn(14'h2123, 0, 8'h00, 1, 1);
    // T4: ROM write timeout, then ack exactly on the timeout cycle, then read back
    do_txn(14'h11FF, 1, 8'h3C, 1000, 1);
    do_txn(14'h11FF, 1, 8'h3C, TO, 1);
    do_txn(14'h11FF, 0, 8'h00, 2, 1);
    // T5: reserved segment with a stalled response
    hold_req = 5;
    do_txn(14'h3000, 0, 8'h00, 0, 1);
    // T6: asynchronous reset while a RAM request is in flight
    do_txn(14'h0000, 1, 8'h00, 0, 1);
    do_txn(14'h2010, 0, 8'h00, 1000, 0);
    t = 0;
    while (!ram_req_o && t < 20) begin @(negedge clk); t++; end
    chk("t6_req_high", ram_req_o, 1);
    #2 rst_n = 0;
    q.delete();
    model_rst = 1;
    #1;
    chk("t6_async_req_drop", ram_req_o, 0);
    chk("t6_sys_rst", sys_rst_o, 1);
    chk("t6_rsp_valid", dbg_rsp_valid, 0);
    @(negedge clk);
    rst_n = 1;
    stale_ack = 1;
    do_txn(14'h0004, 0, 8'h00, 0, 1);
    stale_ack = 0;
    // randomized traffic
    repeat (200) begin
      cpu_pc_i = 12'($urandom); cpu_instr_i = 8'($urandom); cpu_idxreg_i = {$urandom, $urandom};
      seg = $urandom_range(3);
      a12 = seg == 0 ? ($urandom_range(3) == 0 ? $urandom_range(4095) : $urandom_range(17)) : $urandom_range(15);
      hold_req = $urandom_range(3);
      do_txn({2'(seg), 12'(a12)}, 1'($urandom_range(1)), 8'($urandom),
             $urandom_range(5) == 0 ? $urandom_range(TO - 1, TO + 4) : $urandom_range(1, 4), 1);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
